// File: rtl/des_pkg.sv
// DES key-schedule constants, state encoding and bit-permutation helpers (FIPS 46-3).
// Tables use FIPS 1-based bit numbering, where bit 1 is the MSB of each vector.
package des_pkg;
   localparam int KEY_W    = 64;
   localparam int CD_W     = 28;
   localparam int SUBKEY_W = 48;

   localparam int PC1_TAB [0:55] = '{
      57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
      10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
      63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
      14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
   };

   localparam int PC2_TAB [0:47] = '{
      14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
      23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
      41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
      44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
   };

   localparam logic [1:0] SHIFT_TAB [0:15] = '{
      2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
      2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
   };

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACTIVE = 2'd1,
      ST_DONE   = 2'd2
   } state_t;

   // PC1 drops the eight parity bits; result is C in [55:28], D in [27:0].
   function automatic logic [2*CD_W-1:0] pc1(input logic [KEY_W-1:0] k);
      logic [2*CD_W-1:0] r;
      r = '0;
      for (int i = 0; i < 2*CD_W; i++) begin
         r[2*CD_W-1-i] = k[KEY_W-PC1_TAB[i]];
      end
      return r;
   endfunction

   function automatic logic [CD_W-1:0] rotl28(input logic [CD_W-1:0] x, input logic [1:0] n);
      logic [CD_W-1:0] r;
      case (n)
         2'd1:    r = {x[CD_W-2:0], x[CD_W-1]};
         2'd2:    r = {x[CD_W-3:0], x[CD_W-1:CD_W-2]};
         default: r = x;
      endcase
      return r;
   endfunction

   function automatic logic [CD_W-1:0] rotr28(input logic [CD_W-1:0] x, input logic [1:0] n);
      logic [CD_W-1:0] r;
      case (n)
         2'd1:    r = {x[0], x[CD_W-1:1]};
         2'd2:    r = {x[1:0], x[CD_W-1:2]};
         default: r = x;
      endcase
      return r;
   endfunction

   function automatic logic key_parity_ok(input logic [KEY_W-1:0] k);
      logic ok;
      ok = 1'b1;
      for (int b = 0; b < KEY_W/8; b++) begin
         if (!(^k[8*b +: 8])) ok = 1'b0;
      end
      return ok;
   endfunction
endpackage

// File: rtl/des_pc2.sv
// PC2 compression of the 56-bit C||D state into a 48-bit subkey; purely combinational,
// zero latency, no flow control.
module des_pc2
   import des_pkg::*;
(
   input  logic [2*CD_W-1:0]   cd,
   output logic [SUBKEY_W-1:0] subkey
);

   always_comb begin
      subkey = '0;
      for (int i = 0; i < SUBKEY_W; i++) begin
         subkey[SUBKEY_W-1-i] = cd[2*CD_W-PC2_TAB[i]];
      end
   end

endmodule

// File: rtl/des_key_sched_rev.sv
// DES subkey sequencer, forward (K1..K16) or reverse (K16..K1); first subkey 1 cycle after start,
// advances only on valid&ready and holds otherwise. Byte parity check built with DES_KEY_PARITY_CHK_EN.
module des_key_sched_rev
   import des_pkg::*;
(
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic                decrypt,
   input  logic [KEY_W-1:0]    key,
   input  logic                abort,
   input  logic                subkey_ready,
   output logic [SUBKEY_W-1:0] subkey,
   output logic                subkey_valid,
   output logic [3:0]          key_num,
   output logic                busy,
   output logic                done,
   output logic                parity_err
);

   state_t            state, state_nxt;
   logic [CD_W-1:0]   c_reg, d_reg;
   logic [3:0]        round;
   logic              dec_mode;
   logic              load, step;
   logic [2*CD_W-1:0] pc1_key;
   logic [3:0]        shift_idx;
   logic [1:0]        shift_amt;
   logic [SUBKEY_W-1:0] pc2_out;

`ifdef DES_KEY_PARITY_CHK_EN
   logic perr_set, perr_reg, key_par_ok;
   assign key_par_ok = key_parity_ok(key);
`endif

   assign pc1_key = pc1(key);

   des_pc2 u_pc2 (
      .cd     ({c_reg, d_reg}),
      .subkey (pc2_out)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      step      = 1'b0;
`ifdef DES_KEY_PARITY_CHK_EN
      perr_set  = 1'b0;
`endif
      case (state)
         ST_IDLE: begin
            if (start && !abort) begin
`ifdef DES_KEY_PARITY_CHK_EN
               if (key_par_ok) begin
                  state_nxt = ST_ACTIVE;
                  load      = 1'b1;
               end else begin
                  perr_set  = 1'b1;
               end
`else
               state_nxt = ST_ACTIVE;
               load      = 1'b1;
`endif
            end
         end
         ST_ACTIVE: begin
            if (abort) begin
               state_nxt = ST_IDLE;
            end else if (subkey_ready) begin
               step = 1'b1;
               if (round == 4'd15) state_nxt = ST_DONE;
            end
         end
         ST_DONE:  state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   // Shift for the next subkey: forward uses the upcoming round's amount,
   // reverse undoes the amount that produced the current subkey.
   assign shift_idx = dec_mode ? (4'd15 - round) : (round + 4'd1);
   assign shift_amt = SHIFT_TAB[shift_idx];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         c_reg    <= '0;
         d_reg    <= '0;
         round    <= '0;
         dec_mode <= 1'b0;
      end else if (load) begin
         dec_mode <= decrypt;
         round    <= '0;
         if (decrypt) begin
            c_reg <= pc1_key[2*CD_W-1:CD_W];
            d_reg <= pc1_key[CD_W-1:0];
         end else begin
            c_reg <= rotl28(pc1_key[2*CD_W-1:CD_W], 2'd1);
            d_reg <= rotl28(pc1_key[CD_W-1:0], 2'd1);
         end
      end else if (step) begin
         round <= round + 4'd1;
         // The 16th subkey already sits at total rotation 28, so the last handshake leaves C/D alone.
         if (round != 4'd15) begin
            if (dec_mode) begin
               c_reg <= rotr28(c_reg, shift_amt);
               d_reg <= rotr28(d_reg, shift_amt);
            end else begin
               c_reg <= rotl28(c_reg, shift_amt);
               d_reg <= rotl28(d_reg, shift_amt);
            end
         end
      end
   end

`ifdef DES_KEY_PARITY_CHK_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) perr_reg <= 1'b0;
      else        perr_reg <= perr_set;
   end
   assign parity_err = perr_reg;
`else
   assign parity_err = 1'b0;
`endif

   assign busy         = (state != ST_IDLE);
   assign subkey_valid = (state == ST_ACTIVE);
   assign done         = (state == ST_DONE);
   assign subkey       = subkey_valid ? pc2_out : '0;
   assign key_num      = subkey_valid ? (dec_mode ? (4'd15 - round) : round) : 4'd0;

endmodule

// File: tb/tb_des_key_sched_rev.sv
// Randomized and directed bench for des_key_sched_rev against a FIPS 46-3 subkey model
// that computes each Kn directly from the cumulative rotation.
module tb_des_key_sched_rev;

   localparam logic [63:0] KEY_GOOD = 64'h133457799BBCDFF1;
   localparam logic [63:0] KEY_BAD  = 64'h123457799BBCDFF1;
   localparam logic [47:0] K1_GOLD  = 48'h1B02EFFC7072;
   localparam logic [47:0] K16_GOLD = 48'hCB3D8B0E17F5;

   localparam int M_PC1 [0:55] = '{
      57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
      10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
      63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
      14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
   localparam int M_PC2 [0:47] = '{
      14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
      23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
      41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
      44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
   localparam int M_SHIFTS [0:15] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        decrypt = 1'b0;
   logic [63:0] key = '0;
   logic        abort = 1'b0;
   logic        subkey_ready = 1'b0;
   logic [47:0] subkey;
   logic        subkey_valid;
   logic [3:0]  key_num;
   logic        busy;
   logic        done;
   logic        parity_err;

   int total = 0;
   int bad = 0;
   int done_seen = 0;
   logic [47:0] enc_seq [16];

   des_key_sched_rev dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .decrypt      (decrypt),
      .key          (key),
      .abort        (abort),
      .subkey_ready (subkey_ready),
      .subkey       (subkey),
      .subkey_valid (subkey_valid),
      .key_num      (key_num),
      .busy         (busy),
      .done         (done),
      .parity_err   (parity_err)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (done) done_seen++;

   // Kn = PC2 of PC1(key) with both halves rotated left by the sum of the first n shifts.
   function automatic logic [47:0] ref_k(input logic [63:0] k, input int n);
      logic cd0 [56];
      logic cdn [56];
      logic [47:0] r;
      int tot;
      tot = 0;
      for (int i = 0; i < n; i++) tot += M_SHIFTS[i];
      for (int j = 0; j < 56; j++) cd0[j] = k[64 - M_PC1[j]];
      for (int j = 0; j < 28; j++) begin
         cdn[j]      = cd0[(j + tot) % 28];
         cdn[28 + j] = cd0[28 + (j + tot) % 28];
      end
      for (int m = 0; m < 48; m++) r[47 - m] = cdn[M_PC2[m] - 1];
      return r;
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic kick(input logic [63:0] k, input logic dec);
      start = 1'b1; decrypt = dec; key = k;
      tick();
      start = 1'b0;
   endtask

   task automatic run_out;
      int n;
      n = 0;
      subkey_ready = 1'b1;
      while (!done && n < 40) begin tick(); n++; end
      total++;
      if (!done) begin bad++; $display("FAIL run_out: done=%0b required 1 within 40 cycles", done); end
      tick();
   endtask

   task automatic test_reset;
      start = 1'b1; key = KEY_GOOD; subkey_ready = 1'b1;
      repeat (3) tick();
      total++;
      if ({subkey, subkey_valid, key_num, busy, done, parity_err} !== '0) begin
         bad++;
         $display("FAIL reset_outputs: subkey=%h valid=%0b key_num=%0d busy=%0b done=%0b perr=%0b required all 0",
                  subkey, subkey_valid, key_num, busy, done, parity_err);
      end
      start = 1'b0; subkey_ready = 1'b0;
      rst_n = 1'b1;
      tick();
      total++;
      if (busy !== 1'b0) begin bad++; $display("FAIL idle_after_reset: busy=%0b required 0", busy); end
   endtask

   task automatic test_encrypt_known;
      subkey_ready = 1'b1;
      kick(KEY_GOOD, 1'b0);
      for (int r = 0; r < 16; r++) begin
         total++;
         if (subkey_valid !== 1'b1 || subkey !== ref_k(KEY_GOOD, r + 1) || key_num !== 4'(r)) begin
            bad++;
            $display("FAIL enc_round%0d: valid=%0b subkey=%h key_num=%0d required 1 %h %0d",
                     r, subkey_valid, subkey, key_num, ref_k(KEY_GOOD, r + 1), r);
         end
         enc_seq[r] = subkey;
         tick();
      end
      total++;
      if (enc_seq[0] !== K1_GOLD) begin bad++; $display("FAIL enc_first: %h required %h", enc_seq[0], K1_GOLD); end
      total++;
      if (enc_seq[15] !== K16_GOLD) begin bad++; $display("FAIL enc_last: %h required %h", enc_seq[15], K16_GOLD); end
      total++;
      if (done !== 1'b1 || subkey_valid !== 1'b0 || subkey !== '0 || key_num !== 4'd0 || busy !== 1'b1) begin
         bad++;
         $display("FAIL enc_done_cycle: done=%0b valid=%0b subkey=%h key_num=%0d busy=%0b required 1 0 0 0 1",
                  done, subkey_valid, subkey, key_num, busy);
      end
      tick();
      total++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         bad++; $display("FAIL enc_back_idle: done=%0b busy=%0b required 0 0", done, busy);
      end
   endtask

   task automatic test_decrypt_known;
      logic [47:0] dec_seq [16];
      subkey_ready = 1'b1;
      kick(KEY_GOOD, 1'b1);
      for (int r = 0; r < 16; r++) begin
         total++;
         if (subkey_valid !== 1'b1 || subkey !== ref_k(KEY_GOOD, 16 - r) || key_num !== 4'(15 - r)) begin
            bad++;
            $display("FAIL dec_round%0d: valid=%0b subkey=%h key_num=%0d required 1 %h %0d",
                     r, subkey_valid, subkey, key_num, ref_k(KEY_GOOD, 16 - r), 15 - r);
         end
         dec_seq[r] = subkey;
         tick();
      end
      total++;
      if (dec_seq[0] !== K16_GOLD || dec_seq[15] !== K1_GOLD) begin
         bad++; $display("FAIL dec_ends: first=%h last=%h required %h %h", dec_seq[0], dec_seq[15], K16_GOLD, K1_GOLD);
      end
      for (int r = 0; r < 16; r++) begin
         total++;
         if (dec_seq[r] !== enc_seq[15 - r]) begin
            bad++; $display("FAIL dec_reversed%0d: %h required %h", r, dec_seq[r], enc_seq[15 - r]);
         end
      end
      total++;
      if (done !== 1'b1) begin bad++; $display("FAIL dec_done: done=%0b required 1", done); end
      tick();
   endtask

   task automatic test_stall;
      subkey_ready = 1'b1;
      kick(KEY_GOOD, 1'b0);
      repeat (7) tick();
      subkey_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         total++;
         if (subkey_valid !== 1'b1 || subkey !== ref_k(KEY_GOOD, 8) || key_num !== 4'd7) begin
            bad++;
            $display("FAIL stall_hold%0d: valid=%0b subkey=%h key_num=%0d required 1 %h 7",
                     i, subkey_valid, subkey, key_num, ref_k(KEY_GOOD, 8));
         end
      end
      subkey_ready = 1'b1;
      tick();
      total++;
      if (subkey !== ref_k(KEY_GOOD, 9) || key_num !== 4'd8) begin
         bad++; $display("FAIL stall_release: subkey=%h key_num=%0d required %h 8", subkey, key_num, ref_k(KEY_GOOD, 9));
      end
      run_out();
   endtask

   task automatic test_abort;
      int d0;
      subkey_ready = 1'b1;
      kick(KEY_GOOD, 1'b0);
      repeat (9) tick();
      total++;
      if (key_num !== 4'd9) begin bad++; $display("FAIL abort_at_r9: key_num=%0d required 9", key_num); end
      d0 = done_seen;
      abort = 1'b1;
      tick();
      abort = 1'b0;
      total++;
      if (busy !== 1'b0 || subkey_valid !== 1'b0 || subkey !== '0 || key_num !== 4'd0 || done !== 1'b0) begin
         bad++;
         $display("FAIL abort_idle: busy=%0b valid=%0b subkey=%h key_num=%0d done=%0b required all 0",
                  busy, subkey_valid, subkey, key_num, done);
      end
      repeat (3) tick();
      total++;
      if (done_seen !== d0) begin bad++; $display("FAIL abort_no_done: pulses=%0d required %0d", done_seen, d0); end
      kick(KEY_GOOD, 1'b1);
      total++;
      if (subkey !== K16_GOLD || key_num !== 4'd15) begin
         bad++; $display("FAIL abort_restart: subkey=%h key_num=%0d required %h 15", subkey, key_num, K16_GOLD);
      end
      run_out();
   endtask

   task automatic test_reset_mid;
      int d0;
      subkey_ready = 1'b1;
      kick(KEY_GOOD, 1'b0);
      repeat (4) tick();
      d0 = done_seen;
      rst_n = 1'b0;
      #1;
      total++;
      if ({subkey, subkey_valid, key_num, busy, done, parity_err} !== '0) begin
         bad++;
         $display("FAIL reset_mid_async: subkey=%h valid=%0b key_num=%0d busy=%0b done=%0b required all 0",
                  subkey, subkey_valid, key_num, busy, done);
      end
      start = 1'b1; decrypt = 1'b0; key = KEY_GOOD;
      repeat (2) tick();
      total++;
      if (busy !== 1'b0) begin bad++; $display("FAIL reset_blocks_start: busy=%0b required 0", busy); end
      rst_n = 1'b1;
      tick();
      start = 1'b0;
      total++;
      if (busy !== 1'b1 || key_num !== 4'd0 || subkey !== K1_GOLD) begin
         bad++; $display("FAIL reset_then_start: busy=%0b key_num=%0d subkey=%h required 1 0 %h", busy, key_num, subkey, K1_GOLD);
      end
      run_out();
      total++;
      if (done_seen !== d0 + 1) begin bad++; $display("FAIL reset_mid_done_count: %0d required %0d", done_seen, d0 + 1); end
   endtask

   task automatic test_parity;
`ifdef DES_KEY_PARITY_CHK_EN
      kick(KEY_BAD, 1'b0);
      total++;
      if (parity_err !== 1'b1 || busy !== 1'b0) begin
         bad++; $display("FAIL parity_reject: perr=%0b busy=%0b required 1 0", parity_err, busy);
      end
      tick();
      total++;
      if (parity_err !== 1'b0 || busy !== 1'b0) begin
         bad++; $display("FAIL parity_pulse_end: perr=%0b busy=%0b required 0 0", parity_err, busy);
      end
      kick(KEY_GOOD, 1'b0);
      total++;
      if (parity_err !== 1'b0 || busy !== 1'b1 || subkey !== K1_GOLD) begin
         bad++; $display("FAIL parity_accept: perr=%0b busy=%0b subkey=%h required 0 1 %h", parity_err, busy, subkey, K1_GOLD);
      end
`else
      kick(KEY_BAD, 1'b0);
      total++;
      if (parity_err !== 1'b0 || busy !== 1'b1 || subkey !== K1_GOLD) begin
         bad++; $display("FAIL parity_ignored: perr=%0b busy=%0b subkey=%h required 0 1 %h", parity_err, busy, subkey, K1_GOLD);
      end
`endif
      run_out();
   endtask

   task automatic test_random;
      logic [63:0] k;
      logic        dec, rdy;
      int          hs, cyc, n;
      for (int t = 0; t < 8; t++) begin
         k = {$urandom, $urandom};
         for (int b = 0; b < 8; b++) k[8*b] = ~^k[8*b+1 +: 7];
         dec = 1'($urandom_range(0, 1));
         kick(k, dec);
         hs = 0; cyc = 0;
         while (hs < 16 && cyc < 200) begin
            rdy = ($urandom_range(0, 2) != 0);
            subkey_ready = rdy;
            n = dec ? 16 - hs : hs + 1;
            total++;
            if (subkey_valid !== 1'b1 || subkey !== ref_k(k, n) || key_num !== 4'(n - 1)) begin
               bad++;
               $display("FAIL rand%0d_hs%0d: valid=%0b subkey=%h key_num=%0d required 1 %h %0d",
                        t, hs, subkey_valid, subkey, key_num, ref_k(k, n), n - 1);
            end
            tick();
            if (rdy) hs++;
            cyc++;
         end
         total++;
         if (done !== 1'b1 || subkey_valid !== 1'b0) begin
            bad++; $display("FAIL rand%0d_done: done=%0b valid=%0b required 1 0", t, done, subkey_valid);
         end
         tick();
      end
      subkey_ready = 1'b0;
   endtask

   initial begin
      test_reset();
      test_encrypt_known();
      test_decrypt_known();
      test_stall();
      test_abort();
      test_reset_mid();
      test_parity();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

endmodule

// File: doc/des_key_sched_rev.md
DES_KEY_SCHED_REV -- requirements
Module: des_key_sched_rev

Interface
REQ-001 SHALL have no parameters; all tables are fixed by FIPS 46-3.
REQ-002 SHALL have ports: clk  in  1  rising-edge clock; one clock, reset is asynchronous and active-low.
REQ-003 SHALL have: rst_n  in  1  asynchronous active-low reset.
REQ-004 SHALL have: start  in  1  request new schedule; sampled only in IDLE.
REQ-005 SHALL have: decrypt  in  1  sampled with start; 1 = subkeys K16..K1, 0 = K1..K16.
REQ-006 SHALL have: key  in  64  DES key, bit 63 = DES bit 1; sampled with start.
REQ-007 SHALL have: abort  in  1  synchronous return to IDLE.
REQ-008 SHALL have: subkey_ready  in  1  consumer accepts the current subkey.
REQ-009 SHALL have: subkey  out  48  current subkey, PC2 of the C/D registers.
REQ-010 SHALL have: subkey_valid  out  1  subkey is valid.
REQ-011 SHALL have: key_num  out  4  DES subkey index minus 1 (K1 = 0).
REQ-012 SHALL have: busy  out  1  high whenever state is not IDLE.
REQ-013 SHALL have: done  out  1  one-cycle pulse after the 16th subkey is accepted.
REQ-014 SHALL have: parity_err  out  1  one-cycle pulse on a rejected key.

Function
REQ-015 SHALL implement the states IDLE, ACTIVE and DONE.
REQ-016 IDLE with start=1 SHALL go to ACTIVE at the next edge and load the C/D registers (28+28 bits) from PC1(key).
- Encrypt: load rotated left by 1.
- Decrypt: load unrotated.
REQ-017 subkey_valid SHALL be high in every ACTIVE cycle; the first subkey SHALL be valid in the cycle after start is accepted (latency 1).
REQ-018 A handshake SHALL occur when subkey_valid and subkey_ready are both high; C, D and the round counter SHALL change only on a handshake.
- Encrypt: on handshake r (r = 0..14), rotate C and D left by SHIFT[r+1].
- Decrypt: on handshake r, rotate C and D right by SHIFT[15-r].
- SHIFT = 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
REQ-019 key_num SHALL equal r when encrypting and 15-r when decrypting.
REQ-020 While subkey_ready is low, subkey and key_num SHALL stay stable (no timeout).
REQ-021 The handshake at r=15 SHALL move the state to DONE.
- DONE asserts done for 1 cycle with subkey_valid=0, then returns to IDLE.
REQ-022 start SHALL be ignored while busy.
REQ-023 abort SHALL force IDLE at the next edge and SHALL override a simultaneous handshake; done SHALL NOT pulse.
REQ-024 In IDLE and DONE, subkey and key_num SHALL be 0.
REQ-025 After a decrypt schedule, C and D SHALL hold rotl(PC1, 1); after an encrypt schedule, they SHALL hold PC1 (total rotation 28).

Reset
REQ-026 rst_n low SHALL immediately force:
- state = IDLE;
- C, D and the round counter = 0;
- subkey_valid, busy, done, parity_err = 0;
- subkey = 0, key_num = 0.
REQ-027 Reset mid-schedule SHALL discard the schedule; no done pulse SHALL occur.

Configuration
REQ-028 With DES_KEY_PARITY_CHK_EN defined, start in IDLE SHALL check odd parity of each key byte.
- On any even-parity byte: stay in IDLE, pulse parity_err for 1 cycle, load nothing.
REQ-029 Without DES_KEY_PARITY_CHK_EN, parity_err SHALL be tied to 0 and the parity bits SHALL be ignored by PC1.

Structure
REQ-030 A shared package des_pkg SHALL hold:
- PC1 and PC2 tables;
- the SHIFT table;
- the state enum;
- widths: KEY_W = 64, CD_W = 28, SUBKEY_W = 48.
REQ-031 The PC2 permutation SHALL be a combinational sub-module des_pc2 (56 bits in, 48 bits out), reusable by the forward scheduler.

Verification
REQ-032 The bench SHALL cover:
- Encrypt, key 133457799BBCDFF1, subkey_ready=1 -> first subkey 1B02EFFC7072 with key_num=0; 16th subkey CB3D8B0E17F5 with key_num=15; done 1 cycle later.
- Decrypt, same key -> first subkey CB3D8B0E17F5 with key_num=15; last subkey 1B02EFFC7072 with key_num=0; the sequence equals the encrypt sequence reversed.
- subkey_ready held low 5 cycles at r=7 -> subkey and key_num constant, no advance; release -> r=8 next.
- abort at r=9 together with subkey_ready -> IDLE next cycle, busy=0, no done; a new start then works normally.
- rst_n pulsed low at r=4 -> all outputs 0 immediately; start blocked until rst_n is high.
- With DES_KEY_PARITY_CHK_EN: key 123457799BBCDFF1 -> parity_err 1 cycle, busy stays 0; key 133457799BBCDFF1 -> accepted.
